// File: rtl/id_hazard_fwd_unit.sv
// ID-stage forwarding and hazard unit for early branch/JALR resolution.
// Selects compare/target operands from MEM/WB/RF and stalls on unresolvable producers.
module id_hazard_fwd_unit #(
    parameter int          XLEN       = 32,
    parameter int          REG_W      = 5,
    parameter int          CNT_W      = 16,
    parameter int unsigned JALR_IN_ID = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ID_valid,
    input  logic [6:0]       ID_opcode,
    input  logic [REG_W-1:0] ID_ReadRegNum1,
    input  logic [REG_W-1:0] ID_ReadRegNum2,
    input  logic [XLEN-1:0]  RF_ReadData1,
    input  logic [XLEN-1:0]  RF_ReadData2,
    input  logic             EX_cntl_RegWrite,
    input  logic             EX_cntl_MemRead,
    input  logic [REG_W-1:0] EX_WriteRegNum,
    input  logic             MEM_cntl_RegWrite,
    input  logic             MEM_cntl_MemRead,
    input  logic [REG_W-1:0] MEM_WriteRegNum,
    input  logic [XLEN-1:0]  MEM_ALUResult,
    input  logic             WB_cntl_RegWrite,
    input  logic [REG_W-1:0] WB_WriteRegNum,
    input  logic [XLEN-1:0]  WB_WriteData,
    input  logic             flush,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [XLEN-1:0]  ID_Operand1,
    output logic [XLEN-1:0]  ID_Operand2,
    output logic             Stall,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] HazardEvents
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [0:0] {IDLE, STALL_LD} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stallCount_q;
    logic [CNT_W-1:0] hazardEvents_q;

    logic useRs1, useRs2;
    logic memA, memB, wbA, wbB;
    logic exMatch, memLoadMatch;
    logic h1, h2;

    function automatic logic srcMatch(input logic             regWrite,
                                      input logic [REG_W-1:0] rd,
                                      input logic             used,
                                      input logic [REG_W-1:0] rs);
        return regWrite && used && (rd != '0) && (rd == rs);
    endfunction

    assign useRs1 = ID_valid && ((ID_opcode == OPC_BRANCH) ||
                                 ((ID_opcode == OPC_JALR) && (JALR_IN_ID != 0)));
    assign useRs2 = ID_valid && (ID_opcode == OPC_BRANCH);

    // A load still in MEM has no data yet, so it never feeds the 10 path.
    assign memA = srcMatch(MEM_cntl_RegWrite && !MEM_cntl_MemRead, MEM_WriteRegNum, useRs1, ID_ReadRegNum1);
    assign memB = srcMatch(MEM_cntl_RegWrite && !MEM_cntl_MemRead, MEM_WriteRegNum, useRs2, ID_ReadRegNum2);
    assign wbA  = srcMatch(WB_cntl_RegWrite, WB_WriteRegNum, useRs1, ID_ReadRegNum1);
    assign wbB  = srcMatch(WB_cntl_RegWrite, WB_WriteRegNum, useRs2, ID_ReadRegNum2);

    assign exMatch = srcMatch(EX_cntl_RegWrite, EX_WriteRegNum, useRs1, ID_ReadRegNum1) ||
                     srcMatch(EX_cntl_RegWrite, EX_WriteRegNum, useRs2, ID_ReadRegNum2);
    assign memLoadMatch = srcMatch(MEM_cntl_RegWrite && MEM_cntl_MemRead, MEM_WriteRegNum, useRs1, ID_ReadRegNum1) ||
                          srcMatch(MEM_cntl_RegWrite && MEM_cntl_MemRead, MEM_WriteRegNum, useRs2, ID_ReadRegNum2);

    assign h1 = (exMatch && !EX_cntl_MemRead) || memLoadMatch;
    assign h2 = exMatch && EX_cntl_MemRead;

    always_comb begin
        ForwardA = memA ? 2'b10 : (wbA ? 2'b01 : 2'b00);
        ForwardB = memB ? 2'b10 : (wbB ? 2'b01 : 2'b00);
    end

    always_comb begin
        unique case (ForwardA)
            2'b10:   ID_Operand1 = MEM_ALUResult;
            2'b01:   ID_Operand1 = WB_WriteData;
            default: ID_Operand1 = RF_ReadData1;
        endcase
        unique case (ForwardB)
            2'b10:   ID_Operand2 = MEM_ALUResult;
            2'b01:   ID_Operand2 = WB_WriteData;
            default: ID_Operand2 = RF_ReadData2;
        endcase
    end

    // Stall is gated by reset_n so asserting reset drops it without waiting for a clock.
    always_comb begin
        Stall   = 1'b0;
        state_d = IDLE;
        unique case (state_q)
            IDLE: begin
                Stall   = (h1 || h2) && !flush;
                state_d = (h2 && !flush) ? STALL_LD : IDLE;
            end
            STALL_LD: begin
                Stall   = !flush;
                state_d = IDLE;
            end
            default: begin
                Stall   = 1'b0;
                state_d = IDLE;
            end
        endcase
        if (!reset_n) begin
            Stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            stallCount_q   <= '0;
            hazardEvents_q <= '0;
        end else begin
            state_q <= state_d;
            if (Stall && (stallCount_q != '1)) begin
                stallCount_q <= stallCount_q + 1'b1;
            end
            if (Stall && (state_q == IDLE) && (hazardEvents_q != '1)) begin
                hazardEvents_q <= hazardEvents_q + 1'b1;
            end
        end
    end

    assign StallCount   = stallCount_q;
    assign HazardEvents = hazardEvents_q;

endmodule

// File: tb/tb_id_hazard_fwd_unit.sv
// Directed bench for id_hazard_fwd_unit: default instance plus a CNT_W=4, JALR-in-EX instance.
module tb_id_hazard_fwd_unit;

    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] ALU  = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ID_valid;
    logic [6:0]  ID_opcode;
    logic [4:0]  rs1, rs2;
    logic [31:0] rf1, rf2;
    logic        exRw, exMr, memRw, memMr, wbRw, flush;
    logic [4:0]  exRd, memRd, wbRd;
    logic [31:0] memAlu, wbData;

    logic [1:0]  fwdA, fwdB, fwdA2, fwdB2;
    logic [31:0] op1, op2, op1b, op2b;
    logic        stall, stall2;
    logic [15:0] stallCnt, hazEv;
    logic [3:0]  stallCnt2, hazEv2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_hazard_fwd_unit dut (
        .clk(clk), .reset_n(reset_n), .ID_valid(ID_valid), .ID_opcode(ID_opcode),
        .ID_ReadRegNum1(rs1), .ID_ReadRegNum2(rs2), .RF_ReadData1(rf1), .RF_ReadData2(rf2),
        .EX_cntl_RegWrite(exRw), .EX_cntl_MemRead(exMr), .EX_WriteRegNum(exRd),
        .MEM_cntl_RegWrite(memRw), .MEM_cntl_MemRead(memMr), .MEM_WriteRegNum(memRd),
        .MEM_ALUResult(memAlu), .WB_cntl_RegWrite(wbRw), .WB_WriteRegNum(wbRd),
        .WB_WriteData(wbData), .flush(flush), .ForwardA(fwdA), .ForwardB(fwdB),
        .ID_Operand1(op1), .ID_Operand2(op2), .Stall(stall), .StallCount(stallCnt),
        .HazardEvents(hazEv)
    );

    id_hazard_fwd_unit #(.CNT_W(4), .JALR_IN_ID(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .ID_valid(ID_valid), .ID_opcode(ID_opcode),
        .ID_ReadRegNum1(rs1), .ID_ReadRegNum2(rs2), .RF_ReadData1(rf1), .RF_ReadData2(rf2),
        .EX_cntl_RegWrite(exRw), .EX_cntl_MemRead(exMr), .EX_WriteRegNum(exRd),
        .MEM_cntl_RegWrite(memRw), .MEM_cntl_MemRead(memMr), .MEM_WriteRegNum(memRd),
        .MEM_ALUResult(memAlu), .WB_cntl_RegWrite(wbRw), .WB_WriteRegNum(wbRd),
        .WB_WriteData(wbData), .flush(flush), .ForwardA(fwdA2), .ForwardB(fwdB2),
        .ID_Operand1(op1b), .ID_Operand2(op2b), .Stall(stall2), .StallCount(stallCnt2),
        .HazardEvents(hazEv2)
    );

    // Counts every comparison and reports any mismatch on one line.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clearProducers();
        exRw = 0; exMr = 0; exRd = 0;
        memRw = 0; memMr = 0; memRd = 0; memAlu = 32'hAAAA0000;
        wbRw = 0; wbRd = 0; wbData = 32'h55555555;
        flush = 0;
    endtask

    task automatic applyStimulus(input logic v, input logic [6:0] opc,
                                 input logic [4:0] r1, input logic [4:0] r2);
        ID_valid = v; ID_opcode = opc; rs1 = r1; rs2 = r2;
    endtask

    initial begin
        reset_n = 0;
        applyStimulus(0, 7'd0, 5'd0, 5'd0);
        rf1 = 32'h11111111; rf2 = 32'h22222222;
        clearProducers();

        // Reset state
        @(negedge clk); #1;
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_cnt", stallCnt, 0);
        checkOutput("rst_haz", hazEv, 0);
        @(negedge clk); reset_n = 1;

        // No producers
        applyStimulus(1, BR, 5'd1, 5'd2); #1;
        checkOutput("nofwd_A", fwdA, 2'b00);
        checkOutput("nofwd_B", fwdB, 2'b00);
        checkOutput("nofwd_op1", op1, 32'h11111111);
        checkOutput("nofwd_op2", op2, 32'h22222222);
        checkOutput("nofwd_stall", stall, 0);

        // MEM beats WB, then WB alone
        @(negedge clk);
        memRw = 1; memRd = 5'd1; wbRw = 1; wbRd = 5'd1; #1;
        checkOutput("mem_A", fwdA, 2'b10);
        checkOutput("mem_op1", op1, 32'hAAAA0000);
        checkOutput("mem_B", fwdB, 2'b00);
        checkOutput("mem_stall", stall, 0);
        @(negedge clk);
        memRw = 0; #1;
        checkOutput("wb_A", fwdA, 2'b01);
        checkOutput("wb_op1", op1, 32'h55555555);

        // Load in EX feeding rs2: two-cycle episode
        @(negedge clk);
        clearProducers();
        exRw = 1; exMr = 1; exRd = 5'd2; #1;
        checkOutput("ld_stall1", stall, 1);
        @(negedge clk);
        clearProducers();
        memRw = 1; memMr = 1; memRd = 5'd2; #1;
        checkOutput("ld_stall2", stall, 1);
        checkOutput("ld_memload_B", fwdB, 2'b00);
        checkOutput("ld_cnt1", stallCnt, 1);
        checkOutput("ld_haz1", hazEv, 1);
        @(negedge clk);
        clearProducers();
        wbRw = 1; wbRd = 5'd2; wbData = 32'hCAFEF00D; #1;
        checkOutput("ld_stall3", stall, 0);
        checkOutput("ld_wb_B", fwdB, 2'b01);
        checkOutput("ld_wb_op2", op2, 32'hCAFEF00D);
        checkOutput("ld_cnt2", stallCnt, 2);
        checkOutput("ld_haz2", hazEv, 1);

        // Load matched by both ports is still one episode
        @(negedge clk);
        clearProducers();
        applyStimulus(1, BR, 5'd5, 5'd5);
        exRw = 1; exMr = 1; exRd = 5'd5; #1;
        checkOutput("both_stall1", stall, 1);
        @(negedge clk);
        clearProducers();
        memRw = 1; memMr = 1; memRd = 5'd5; #1;
        checkOutput("both_stall2", stall, 1);
        @(negedge clk);
        clearProducers(); #1;
        checkOutput("both_stall3", stall, 0);
        checkOutput("both_cnt", stallCnt, 4);
        checkOutput("both_haz", hazEv, 2);

        // JALR with ALU producer in EX
        @(negedge clk);
        applyStimulus(1, JALR, 5'd3, 5'd4);
        exRw = 1; exRd = 5'd3; memRw = 1; memRd = 5'd4; #1;
        checkOutput("jalr_stall", stall, 1);
        checkOutput("jalr_B_unused", fwdB, 2'b00);
        checkOutput("jalrEx_stall", stall2, 0);
        checkOutput("jalrEx_A", fwdA2, 2'b00);
        @(negedge clk);
        clearProducers(); #1;
        checkOutput("jalr_after", stall, 0);
        checkOutput("jalr_cnt", stallCnt, 5);
        checkOutput("jalr_haz", hazEv, 3);

        // Register zero never forwards or stalls
        applyStimulus(1, BR, 5'd0, 5'd0);
        exRw = 1; exMr = 1; exRd = 0; memRw = 1; memRd = 0; wbRw = 1; wbRd = 0; #1;
        checkOutput("x0_stall", stall, 0);
        checkOutput("x0_A", fwdA, 2'b00);
        checkOutput("x0_B", fwdB, 2'b00);
        checkOutput("x0_op1", op1, 32'h11111111);

        // Non-consumer opcode and invalid ID
        @(negedge clk);
        clearProducers();
        applyStimulus(1, ALU, 5'd9, 5'd9);
        exRw = 1; exMr = 1; exRd = 5'd9; memRw = 1; memRd = 5'd9; #1;
        checkOutput("alu_stall", stall, 0);
        checkOutput("alu_A", fwdA, 2'b00);
        applyStimulus(0, BR, 5'd9, 5'd9); #1;
        checkOutput("inv_stall", stall, 0);
        checkOutput("inv_B", fwdB, 2'b00);

        // Flush during the second load-stall cycle
        @(negedge clk);
        clearProducers();
        applyStimulus(1, BR, 5'd6, 5'd0);
        exRw = 1; exMr = 1; exRd = 5'd6; #1;
        checkOutput("fl_stall1", stall, 1);
        @(negedge clk);
        clearProducers();
        memRw = 1; memMr = 1; memRd = 5'd6; flush = 1; #1;
        checkOutput("fl_stall2", stall, 0);
        @(negedge clk);
        clearProducers(); #1;
        checkOutput("fl_idle", stall, 0);
        checkOutput("fl_cnt", stallCnt, 6);
        checkOutput("fl_haz", hazEv, 4);

        // Reset asserted mid-STALL_LD
        @(negedge clk);
        applyStimulus(1, BR, 5'd7, 5'd0);
        exRw = 1; exMr = 1; exRd = 5'd7;
        @(negedge clk);
        clearProducers();
        memRw = 1; memMr = 1; memRd = 5'd7; #1;
        checkOutput("rs_stall_before", stall, 1);
        reset_n = 0; #1;
        checkOutput("rs_stall", stall, 0);
        checkOutput("rs_cnt", stallCnt, 0);
        checkOutput("rs_haz", hazEv, 0);
        memMr = 0; #1;
        checkOutput("rs_fwdA", fwdA, 2'b10);
        checkOutput("rs_op1", op1, 32'hAAAA0000);
        @(negedge clk);
        clearProducers();
        reset_n = 1;

        // 20 continuous stall cycles: 4-bit counters saturate
        @(negedge clk);
        applyStimulus(1, BR, 5'd8, 5'd0);
        exRw = 1; exRd = 5'd8;
        repeat (20) @(negedge clk);
        #1;
        checkOutput("sat_cnt4", stallCnt2, 4'd15);
        checkOutput("sat_haz4", hazEv2, 4'd15);
        checkOutput("sat_cnt16", stallCnt, 20);
        checkOutput("sat_haz16", hazEv, 20);
        clearProducers();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_hazard_fwd_unit.md
ID_HAZARD_FWD_UNIT -- requirements
Module: id_hazard_fwd_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning): XLEN, 32, operand data width; REG_W, 5, register-number width; CNT_W, 16, stall-counter width; JALR_IN_ID, 1, JALR target resolved in ID (1) or EX (0).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 ID_valid  in  1  ID holds a live instruction; ID_opcode  in  7  ID opcode.
REQ-005 ID_ReadRegNum1, ID_ReadRegNum2  in  REG_W each  ID source registers.
REQ-006 RF_ReadData1, RF_ReadData2  in  XLEN each  register-file read data (write-before-read RF).
REQ-007 EX_cntl_RegWrite, EX_cntl_MemRead  in  1 each; EX_WriteRegNum  in  REG_W.
REQ-008 MEM_cntl_RegWrite, MEM_cntl_MemRead  in  1 each; MEM_WriteRegNum  in  REG_W; MEM_ALUResult  in  XLEN.
REQ-009 WB_cntl_RegWrite  in  1; WB_WriteRegNum  in  REG_W; WB_WriteData  in  XLEN.
REQ-010 flush  in  1  ID squash (taken branch/jump).
REQ-011 ForwardA, ForwardB  out  2 each  00 RF, 01 WB, 10 MEM.
REQ-012 ID_Operand1, ID_Operand2  out  XLEN each  forwarded compare/target operands.
REQ-013 Stall  out  1  freeze PC and IF/ID, bubble into ID/EX.
REQ-014 StallCount  out  CNT_W  saturating count of stall cycles; HazardEvents  out  CNT_W  saturating count of stall episodes.

Function
REQ-015 Consumer: branch (1100011) uses rs1, rs2; JALR (1100111) uses rs1 only when JALR_IN_ID=1; all else, or ID_valid=0, SHALL give Forward=00, no stall.
REQ-016 Producer matches only if RegWrite=1, WriteRegNum!=0, WriteRegNum equals a used source.
REQ-017 Per port: MEM non-load match -> 10 (MEM_ALUResult); else WB match -> 01 (WB_WriteData); else 00 (RF_ReadData); MEM beats WB.
REQ-018 ID_Operandn SHALL be the mux selected by Forwardn, same cycle (combinational).
REQ-019 Hazards: EX non-load match -> H1; MEM load match -> H1; EX load match -> H2.
REQ-020 FSM states IDLE, STALL_LD; reset state IDLE.
REQ-021 IDLE: Stall = (H1|H2) & ~flush; H2 & ~flush -> STALL_LD; else stay IDLE.
REQ-022 STALL_LD: Stall=1 irrespective of H1/H2; next IDLE; flush -> Stall=0, next IDLE.
REQ-023 While Stall=1, Forward outputs SHALL still be computed per REQ-017 (don't-care downstream).
REQ-024 StallCount +1 each Stall=1 cycle; HazardEvents +1 on each IDLE cycle with Stall=1; both hold at 2^CNT_W-1.
REQ-025 A load in EX matched by both ports SHALL give one 2-cycle episode (one HazardEvents increment).

Reset
REQ-026 reset_n=0 SHALL asynchronously force state IDLE, StallCount=0, HazardEvents=0, Stall=0 regardless of clk.
REQ-027 During reset, Forward/ID_Operand outputs SHALL follow REQ-017 combinationally; reset in STALL_LD SHALL end stall immediately.

Verification
REQ-028 Branch rs1=1, rs2=2, no producers -> ForwardA=ForwardB=00, operands=RF data, Stall=0.
REQ-029 Branch rs1=1; MEM ALU rd=1 (0xAAAA0000), WB rd=1 (0x55555555) -> ForwardA=10, ID_Operand1=0xAAAA0000, Stall=0.
REQ-030 Branch rs2=2; EX load rd=2 -> Stall=1 two cycles (IDLE->STALL_LD->IDLE), HazardEvents=1, StallCount=2; then MEM/WB forwarding resolves.
REQ-031 JALR rs1=3, EX ALU rd=3 -> Stall=1 one cycle; JALR_IN_ID=0 -> Stall=0, Forward=00; producer rd=0 -> never forwards or stalls.
REQ-032 EX-load hazard, flush in STALL_LD cycle -> Stall=0 that cycle, IDLE next; reset_n low mid-STALL_LD -> Stall=0 immediately, counters 0.
REQ-033 CNT_W=4, 20 stall cycles -> StallCount saturates at 15.
